load_store_unit: RTL and testbench

//  Memory-stage load/store sequencer feeding dataMemory (word-addressed, 256x32,

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and dataMemory bus of the load/store unit.
// master: execute stage plus memory side; slave: the load_store_unit itself.
interface load_store_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_load;
   logic              req_byte;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_fault;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_dataIn;
   logic              mem_enable;
   logic              mem_readNotWrite;
   logic [31:0]       mem_dataOut;

   modport master (
      output req_valid, req_load, req_byte, req_signed, req_addr, req_wdata, mem_dataOut,
      input  req_ready, resp_valid, resp_rdata, resp_fault,
      input  mem_addr, mem_dataIn, mem_enable, mem_readNotWrite
   );

   modport slave (
      input  req_valid, req_load, req_byte, req_signed, req_addr, req_wdata, mem_dataOut,
      output req_ready, resp_valid, resp_rdata, resp_fault,
      output mem_addr, mem_dataIn, mem_enable, mem_readNotWrite
   );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store sequencer: byte/word requests to word accesses, byte stores by RMW.
// Define LSU_SIGNEXT_EN to sign-extend byte loads that have req_signed set.
module load_store_unit #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned MEM_WORDS = 256
) (
   input logic              clk,
   input logic              reset,
   load_store_unit_if.slave bus
);
   localparam int unsigned IdxW = $clog2(MEM_WORDS);

   typedef enum logic [2:0] {StIdle, StRd, StRdw, StWr, StResp} state_e;
   state_e state_q, state_d;

   logic        op_load_q, op_byte_q;
   logic [1:0]  lane_q;
   logic [7:0]  wbyte_q;
   logic        accept, misaligned;
   logic [7:0]  rbyte;
   logic [31:0] load_val, merged;

   logic        req_ready_d, resp_valid_d, resp_fault_d, mem_enable_d, mem_rnw_d;
   logic [31:0] resp_rdata_d, mem_addr_d, mem_dataIn_d;

   assign accept     = bus.req_valid & bus.req_ready;
   assign misaligned = ~bus.req_byte & (bus.req_addr[1:0] != 2'b00);

`ifdef LSU_SIGNEXT_EN
   logic op_signed_q;
   logic unused_bits;
   assign unused_bits = ^bus.req_addr[ADDR_W-1:IdxW+2];
`else
   logic unused_bits;
   assign unused_bits = ^{bus.req_addr[ADDR_W-1:IdxW+2], bus.req_signed};
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (misaligned) begin
                  state_d = StResp;
               end else if (bus.req_load || bus.req_byte) begin
                  state_d = StRd;
               end else begin
                  state_d = StWr;
               end
            end
         end
         StRd:    state_d = StRdw;
         StRdw:   state_d = op_load_q ? StResp : StWr;
         StWr:    state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Lane extract for byte loads and lane merge for byte-store RMW.
   always_comb begin
      rbyte  = bus.mem_dataOut[{lane_q, 3'b000} +: 8];
      merged = bus.mem_dataOut;
      merged[{lane_q, 3'b000} +: 8] = wbyte_q;
      if (op_byte_q) begin
`ifdef LSU_SIGNEXT_EN
         load_val = {{24{op_signed_q & rbyte[7]}}, rbyte};
`else
         load_val = {24'h0, rbyte};
`endif
      end else begin
         load_val = bus.mem_dataOut;
      end
   end

   always_comb begin
      req_ready_d  = (state_d == StIdle);
      resp_valid_d = (state_d == StResp);
      mem_enable_d = (state_d == StRd) || (state_d == StWr);
      mem_rnw_d    = (state_d != StWr);
      resp_fault_d = 1'b0;
      resp_rdata_d = 32'h0;
      mem_addr_d   = bus.mem_addr;
      mem_dataIn_d = bus.mem_dataIn;
      if (accept) begin
         resp_fault_d = misaligned;
         mem_addr_d   = {{(32-IdxW){1'b0}}, bus.req_addr[IdxW+1:2]};
         mem_dataIn_d = bus.req_wdata;
      end
      if (state_q == StRdw) begin
         if (op_load_q) begin
            resp_rdata_d = load_val;
         end else begin
            mem_dataIn_d = merged;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.req_ready        <= 1'b1;
         bus.resp_valid       <= 1'b0;
         bus.resp_rdata       <= 32'h0;
         bus.resp_fault       <= 1'b0;
         bus.mem_addr         <= 32'h0;
         bus.mem_dataIn       <= 32'h0;
         bus.mem_enable       <= 1'b0;
         bus.mem_readNotWrite <= 1'b1;
      end else begin
         bus.req_ready        <= req_ready_d;
         bus.resp_valid       <= resp_valid_d;
         bus.resp_rdata       <= resp_rdata_d;
         bus.resp_fault       <= resp_fault_d;
         bus.mem_addr         <= mem_addr_d;
         bus.mem_dataIn       <= mem_dataIn_d;
         bus.mem_enable       <= mem_enable_d;
         bus.mem_readNotWrite <= mem_rnw_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         op_load_q <= 1'b0;
         op_byte_q <= 1'b0;
         lane_q    <= 2'b00;
         wbyte_q   <= 8'h0;
`ifdef LSU_SIGNEXT_EN
         op_signed_q <= 1'b0;
`endif
      end else if (accept) begin
         op_load_q <= bus.req_load;
         op_byte_q <= bus.req_byte;
         lane_q    <= bus.req_addr[1:0];
         wbyte_q   <= bus.req_wdata[7:0];
`ifdef LSU_SIGNEXT_EN
         op_signed_q <= bus.req_signed;
`endif
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: memory model, shadow memory and response scoreboard.
module tb_load_store_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   load_store_unit_if bus ();

   load_store_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          due;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem [256];
   logic [31:0] shadow [256];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_issued = 0;
   int          n_resp = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // dataMemory: registered dataOut, write on enable with readNotWrite low
   always @(posedge clk) begin
      if (bus.mem_enable) begin
         if (bus.mem_readNotWrite) bus.mem_dataOut <= mem[bus.mem_addr[7:0]];
         else mem[bus.mem_addr[7:0]] <= bus.mem_dataIn;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (sb.size() != 0) check("ready_low_busy", {31'h0, bus.req_ready}, 32'h0);
         if (bus.resp_valid === 1'b1) begin
            n_resp++;
            check("resp_expected", {31'h0, sb.size() != 0}, 32'h1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("resp_rdata", bus.resp_rdata, e.rdata);
               check("resp_fault", {31'h0, bus.resp_fault}, {31'h0, e.fault});
               check("resp_cycle", cyc, e.due);
            end
         end
      end
   end

   task automatic issue(input logic ld, input logic by, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wdata);
      int          waits = 0;
      int          lat;
      logic [7:0]  idx;
      logic [7:0]  b;
      logic        ext;
      exp_t        e;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_load   = ld;
      bus.req_byte   = by;
      bus.req_signed = sg;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      while (bus.req_ready !== 1'b1 && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      check("ready_wait", {31'h0, bus.req_ready}, 32'h1);
      idx     = addr[9:2];
      e.rdata = 32'h0;
      e.fault = 1'b0;
      if (!by && addr[1:0] != 2'b00) begin
         e.fault = 1'b1;
         lat     = 1;
      end else if (ld) begin
         lat = 3;
         if (by) begin
            b   = shadow[idx][{addr[1:0], 3'b000} +: 8];
`ifdef LSU_SIGNEXT_EN
            ext = sg & b[7];
`else
            ext = 1'b0;
`endif
            e.rdata = {{24{ext}}, b};
         end else begin
            e.rdata = shadow[idx];
         end
      end else if (by) begin
         lat = 4;
         shadow[idx][{addr[1:0], 3'b000} +: 8] = wdata[7:0];
      end else begin
         lat = 2;
         shadow[idx] = wdata;
      end
      @(posedge clk);
      #1;
      e.due = cyc + lat - 1;
      sb.push_back(e);
      n_issued++;
   endtask

   task automatic release_req();
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("drain_empty", sb.size(), 32'h0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
      check({tag, "_rvalid"}, {31'h0, bus.resp_valid}, 32'h0);
      check({tag, "_rdata"}, bus.resp_rdata, 32'h0);
      check({tag, "_fault"}, {31'h0, bus.resp_fault}, 32'h0);
      check({tag, "_maddr"}, bus.mem_addr, 32'h0);
      check({tag, "_mdin"}, bus.mem_dataIn, 32'h0);
      check({tag, "_men"}, {31'h0, bus.mem_enable}, 32'h0);
      check({tag, "_mrnw"}, {31'h0, bus.mem_readNotWrite}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]    = 32'h0;
         shadow[i] = 32'h0;
      end
      reset          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_load   = 1'b0;
      bus.req_byte   = 1'b0;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b1;

      // Reset during byte-store RMW: no write, no response.
      issue(1'b0, 1'b0, 1'b0, 32'h20, 32'h12345678);
      release_req();
      drain();
      issue(1'b0, 1'b1, 1'b0, 32'h21, 32'h000000AA);
      @(negedge clk);
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      sb.delete();
      shadow[8] = 32'h12345678;
      n_issued--;
      repeat (2) @(negedge clk);
      check_reset_outputs("midrst");
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("midrst_men", {31'h0, bus.mem_enable}, 32'h0);
      end
      check("midrst_mem", mem[8], 32'h12345678);

      // Word store then load.
      issue(1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
      release_req();
      drain();
      check("str_mem", mem[4], 32'hDEADBEEF);
      issue(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      release_req();
      drain();

      // Byte store merge.
      issue(1'b0, 1'b1, 1'b0, 32'h11, 32'hFFFFFF55);
      release_req();
      drain();
      issue(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      release_req();
      drain();

      // Byte loads, zero and sign extension.
      issue(1'b0, 1'b0, 1'b0, 32'h10, 32'h80AA0000);
      issue(1'b1, 1'b1, 1'b0, 32'h13, 32'h0);
      issue(1'b1, 1'b1, 1'b1, 32'h13, 32'h0);
      issue(1'b1, 1'b1, 1'b1, 32'h12, 32'h0);
      release_req();
      drain();

      // Misaligned word load: fault, no memory activity.
      issue(1'b1, 1'b0, 1'b0, 32'h12, 32'h0);
      release_req();
      repeat (3) begin
         check("fault_men", {31'h0, bus.mem_enable}, 32'h0);
         @(negedge clk);
      end
      drain();

      // Back-to-back with req_valid held, including address wrap and a fault.
      issue(1'b0, 1'b0, 1'b0, 32'h404, 32'h11112222);
      issue(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      issue(1'b1, 1'b1, 1'b0, 32'h6, 32'h0);
      issue(1'b0, 1'b0, 1'b0, 32'h9, 32'h0);
      issue(1'b0, 1'b1, 1'b0, 32'hFFFF_F007, 32'h00000099);
      issue(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      release_req();
      drain();
      check("resp_count", n_resp, n_issued);
      check("wrap_mem", mem[1], 32'h99112222);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
